// File: rtl/rs_alu.sv
// Reservation station for the integer ALU pipe: holds renamed micro-ops until both
// sources are ready, tracks two wakeup buses and issues the lowest-index ready op.
module rs_alu #(
    parameter int DEPTH    = 8,
    parameter int PTAG_W   = 7,
    parameter int ROB_SIZE = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PTAG_W-1:0]          disp_pd,
    input  logic [PTAG_W-1:0]          disp_ps1,
    input  logic [PTAG_W-1:0]          disp_ps2,
    input  logic                       disp_ps1_rdy,
    input  logic                       disp_ps2_rdy,
    input  logic [4:0]                 disp_rob_index,
    input  logic [6:0]                 disp_opcode,
    input  logic [2:0]                 disp_func3,
    input  logic [6:0]                 disp_func7,
    input  logic [31:0]                disp_imm,
    input  logic                       wk0_valid,
    input  logic [PTAG_W-1:0]          wk0_tag,
    input  logic                       wk1_valid,
    input  logic [PTAG_W-1:0]          wk1_tag,
    input  logic                       fu_ready,
    output logic                       issued,
    output logic [PTAG_W-1:0]          iss_pd,
    output logic [PTAG_W-1:0]          iss_ps1,
    output logic [PTAG_W-1:0]          iss_ps2,
    output logic [4:0]                 iss_rob_index,
    output logic [6:0]                 iss_opcode,
    output logic [2:0]                 iss_func3,
    output logic [6:0]                 iss_func7,
    output logic [31:0]                iss_imm,
    input  logic                       mispredict,
    input  logic [4:0]                 mispredict_tag,
    input  logic [4:0]                 rob_tail,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_rdy1;
    logic [DEPTH-1:0]  r_rdy2;
    logic [PTAG_W-1:0] r_pd   [DEPTH];
    logic [PTAG_W-1:0] r_ps1  [DEPTH];
    logic [PTAG_W-1:0] r_ps2  [DEPTH];
    logic [4:0]        r_rob  [DEPTH];
    logic [6:0]        r_opc  [DEPTH];
    logic [2:0]        r_f3   [DEPTH];
    logic [6:0]        r_f7   [DEPTH];
    logic [31:0]       r_imm  [DEPTH];

    logic              w_free_found;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_sel_found;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_disp_we;
    logic              w_issue;
    logic [CNT_W-1:0]  w_occ;

    // Tag 0 is hardwired ready; otherwise ready when either wakeup bus carries the tag.
    function automatic logic tag_ready(input logic [PTAG_W-1:0] tag,
                                       input logic v0, input logic [PTAG_W-1:0] t0,
                                       input logic v1, input logic [PTAG_W-1:0] t1);
        return (tag == '0) || (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    // Younger-than-branch test on the circular ROB: offsets measured from branch+1.
    function automatic logic in_flush(input logic [4:0] rob, input logic [4:0] br,
                                      input logic [4:0] tail);
        int d_e;
        int d_t;
        d_e = (int'(rob)  - int'(br) - 1 + 2 * ROB_SIZE) % ROB_SIZE;
        d_t = (int'(tail) - int'(br) - 1 + 2 * ROB_SIZE) % ROB_SIZE;
        return d_e < d_t;
    endfunction

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        w_occ        = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (r_valid[i] && r_rdy1[i] && r_rdy2[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
            w_occ = w_occ + CNT_W'(r_valid[i]);
        end
    end

    assign disp_ready = w_free_found;
    assign w_disp_we  = disp_valid && w_free_found && !mispredict;
    assign w_issue    = fu_ready && w_sel_found && !mispredict;
    assign occupancy  = w_occ;

    assign issued        = w_issue;
    assign iss_pd        = w_issue ? r_pd[w_sel_idx]  : '0;
    assign iss_ps1       = w_issue ? r_ps1[w_sel_idx] : '0;
    assign iss_ps2       = w_issue ? r_ps2[w_sel_idx] : '0;
    assign iss_rob_index = w_issue ? r_rob[w_sel_idx] : '0;
    assign iss_opcode    = w_issue ? r_opc[w_sel_idx] : '0;
    assign iss_func3     = w_issue ? r_f3[w_sel_idx]  : '0;
    assign iss_func7     = w_issue ? r_f7[w_sel_idx]  : '0;
    assign iss_imm       = w_issue ? r_imm[w_sel_idx] : '0;

    // Occupancy bits: dispatch target and issue/flush victims are always distinct entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mispredict && r_valid[i] && in_flush(r_rob[i], mispredict_tag, rob_tail))
                    r_valid[i] <= 1'b0;
            end
            if (w_issue)
                r_valid[w_sel_idx] <= 1'b0;
            if (w_disp_we)
                r_valid[w_free_idx] <= 1'b1;
        end
    end

    // Entry payload and readiness; contents of invalid entries are don't-care.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                r_rdy1[i] <= r_rdy1[i] | tag_ready(r_ps1[i], wk0_valid, wk0_tag, wk1_valid, wk1_tag);
                r_rdy2[i] <= r_rdy2[i] | tag_ready(r_ps2[i], wk0_valid, wk0_tag, wk1_valid, wk1_tag);
            end
        end
        if (w_disp_we) begin
            r_pd[w_free_idx]   <= disp_pd;
            r_ps1[w_free_idx]  <= disp_ps1;
            r_ps2[w_free_idx]  <= disp_ps2;
            r_rob[w_free_idx]  <= disp_rob_index;
            r_opc[w_free_idx]  <= disp_opcode;
            r_f3[w_free_idx]   <= disp_func3;
            r_f7[w_free_idx]   <= disp_func7;
            r_imm[w_free_idx]  <= disp_imm;
            r_rdy1[w_free_idx] <= disp_ps1_rdy |
                                  tag_ready(disp_ps1, wk0_valid, wk0_tag, wk1_valid, wk1_tag);
            r_rdy2[w_free_idx] <= disp_ps2_rdy |
                                  tag_ready(disp_ps2, wk0_valid, wk0_tag, wk1_valid, wk1_tag);
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: dispatch, wakeup timing, full stall, flush, select order, reset.
module tb_rs_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic        disp_valid;
    logic        disp_ready;
    logic [6:0]  disp_pd, disp_ps1, disp_ps2;
    logic        disp_ps1_rdy, disp_ps2_rdy;
    logic [4:0]  disp_rob_index;
    logic [6:0]  disp_opcode;
    logic [2:0]  disp_func3;
    logic [6:0]  disp_func7;
    logic [31:0] disp_imm;
    logic        wk0_valid, wk1_valid;
    logic [6:0]  wk0_tag, wk1_tag;
    logic        fu_ready;
    logic        issued;
    logic [6:0]  iss_pd, iss_ps1, iss_ps2;
    logic [4:0]  iss_rob_index;
    logic [6:0]  iss_opcode;
    logic [2:0]  iss_func3;
    logic [6:0]  iss_func7;
    logic [31:0] iss_imm;
    logic        mispredict;
    logic [4:0]  mispredict_tag, rob_tail;
    logic [3:0]  occupancy;

    int n_pass = 0;
    int n_total = 0;

    rs_alu #(.DEPTH(8), .PTAG_W(7), .ROB_SIZE(16)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_pd(disp_pd), .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
        .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
        .disp_rob_index(disp_rob_index), .disp_opcode(disp_opcode),
        .disp_func3(disp_func3), .disp_func7(disp_func7), .disp_imm(disp_imm),
        .wk0_valid(wk0_valid), .wk0_tag(wk0_tag), .wk1_valid(wk1_valid), .wk1_tag(wk1_tag),
        .fu_ready(fu_ready), .issued(issued),
        .iss_pd(iss_pd), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2),
        .iss_rob_index(iss_rob_index), .iss_opcode(iss_opcode),
        .iss_func3(iss_func3), .iss_func7(iss_func7), .iss_imm(iss_imm),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag), .rob_tail(rob_tail),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic set_op(input logic [6:0] pd, input logic [6:0] ps1, input logic r1,
                          input logic [6:0] ps2, input logic r2, input logic [4:0] rob,
                          input logic [31:0] imm);
        disp_pd = pd; disp_ps1 = ps1; disp_ps1_rdy = r1;
        disp_ps2 = ps2; disp_ps2_rdy = r2; disp_rob_index = rob; disp_imm = imm;
    endtask

    task automatic disp(input logic [6:0] pd, input logic [6:0] ps1, input logic r1,
                        input logic [6:0] ps2, input logic r2, input logic [4:0] rob);
        set_op(pd, ps1, r1, ps2, r2, rob, 32'h0);
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; disp_valid = 1'b0; fu_ready = 1'b1;
        set_op(7'd0, 7'd0, 1'b0, 7'd0, 1'b0, 5'd0, 32'h0);
        disp_opcode = 7'h13; disp_func3 = 3'd0; disp_func7 = 7'd0;
        wk0_valid = 1'b0; wk0_tag = 7'd0; wk1_valid = 1'b0; wk1_tag = 7'd0;
        mispredict = 1'b0; mispredict_tag = 5'd0; rob_tail = 5'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_issued", 32'(issued), 32'd0);
        chk("rst_iss_pd", 32'(iss_pd), 32'd0);

        // addi, both sources ready: issues the cycle after dispatch
        set_op(7'd5, 7'd1, 1'b1, 7'd2, 1'b1, 5'd3, 32'h10);
        disp_valid = 1'b1;
        #1;
        chk("addi_same_cycle", 32'(issued), 32'd0);
        tick();
        disp_valid = 1'b0;
        #1;
        chk("addi_occ1", 32'(occupancy), 32'd1);
        chk("addi_issued", 32'(issued), 32'd1);
        chk("addi_pd", 32'(iss_pd), 32'd5);
        chk("addi_rob", 32'(iss_rob_index), 32'd3);
        chk("addi_imm", iss_imm, 32'h10);
        chk("addi_opc", 32'(iss_opcode), 32'h13);
        tick();
        chk("addi_occ0", 32'(occupancy), 32'd0);
        chk("addi_idle", 32'(issued), 32'd0);

        // sub with ps1 waiting on tag 9; wakeup in N -> issue in N+1
        disp(7'd10, 7'd9, 1'b0, 7'd0, 1'b0, 5'd4);
        chk("sub_wait", 32'(issued), 32'd0);
        wk0_valid = 1'b1; wk0_tag = 7'd9;
        #1;
        chk("sub_wake_cycle", 32'(issued), 32'd0);
        tick();
        wk0_valid = 1'b0;
        #1;
        chk("sub_issued", 32'(issued), 32'd1);
        chk("sub_pd", 32'(iss_pd), 32'd10);
        tick();

        // wakeup on both buses in the dispatch cycle
        set_op(7'd11, 7'd20, 1'b0, 7'd21, 1'b0, 5'd5, 32'h0);
        disp_valid = 1'b1;
        wk0_valid = 1'b1; wk0_tag = 7'd20; wk1_valid = 1'b1; wk1_tag = 7'd21;
        tick();
        disp_valid = 1'b0; wk0_valid = 1'b0; wk1_valid = 1'b0;
        #1;
        chk("bypass_issued", 32'(issued), 32'd1);
        chk("bypass_pd", 32'(iss_pd), 32'd11);
        tick();
        chk("bypass_occ0", 32'(occupancy), 32'd0);

        // fill all eight with waiting ops; entry i waits on tag 30+i
        for (int i = 0; i < 8; i++)
            disp(7'(40 + i), 7'(30 + i), 1'b0, 7'd0, 1'b0, 5'(i));
        chk("full_occ", 32'(occupancy), 32'd8);
        chk("full_ready", 32'(disp_ready), 32'd0);
        disp(7'd99, 7'd1, 1'b1, 7'd2, 1'b1, 5'd9);
        chk("full_reject", 32'(occupancy), 32'd8);
        chk("full_no_issue", 32'(issued), 32'd0);
        wk0_valid = 1'b1; wk0_tag = 7'd32;
        tick();
        wk0_valid = 1'b0;
        #1;
        chk("full_e2_issued", 32'(issued), 32'd1);
        chk("full_e2_pd", 32'(iss_pd), 32'd42);
        chk("full_still_full", 32'(disp_ready), 32'd0);
        tick();
        chk("full_ready_after", 32'(disp_ready), 32'd1);
        chk("full_occ7", 32'(occupancy), 32'd7);

        reset = 1'b1; tick(); reset = 1'b0;

        // rob 14(ready),15,0,1; branch 15, tail 2 flushes rob 0 and 1
        fu_ready = 1'b0;
        disp(7'd50, 7'd0, 1'b0, 7'd0, 1'b0, 5'd14);
        disp(7'd51, 7'd61, 1'b0, 7'd0, 1'b0, 5'd15);
        disp(7'd52, 7'd62, 1'b0, 7'd0, 1'b0, 5'd0);
        disp(7'd53, 7'd63, 1'b0, 7'd0, 1'b0, 5'd1);
        chk("mp_occ4", 32'(occupancy), 32'd4);
        mispredict = 1'b1; mispredict_tag = 5'd15; rob_tail = 5'd2; fu_ready = 1'b1;
        set_op(7'd55, 7'd1, 1'b1, 7'd2, 1'b1, 5'd5, 32'h0);
        disp_valid = 1'b1;
        #1;
        chk("mp_issued0", 32'(issued), 32'd0);
        tick();
        mispredict = 1'b0; disp_valid = 1'b0; fu_ready = 1'b0;
        #1;
        chk("mp_occ2", 32'(occupancy), 32'd2);
        fu_ready = 1'b1;
        #1;
        chk("mp_rob14_issue", 32'(iss_rob_index), 32'd14);
        chk("mp_rob14_pd", 32'(iss_pd), 32'd50);
        tick();
        chk("mp_rob15_wait", 32'(issued), 32'd0);
        chk("mp_occ1", 32'(occupancy), 32'd1);
        wk1_valid = 1'b1; wk1_tag = 7'd61;
        tick();
        wk1_valid = 1'b0;
        #1;
        chk("mp_rob15_issue", 32'(iss_rob_index), 32'd15);
        tick();
        chk("mp_empty", 32'(occupancy), 32'd0);

        // ready ops in entries 1 and 4, held off by fu_ready
        fu_ready = 1'b0;
        disp(7'd80, 7'd70, 1'b0, 7'd0, 1'b0, 5'd6);
        disp(7'd81, 7'd1, 1'b1, 7'd2, 1'b1, 5'd7);
        disp(7'd82, 7'd72, 1'b0, 7'd0, 1'b0, 5'd8);
        disp(7'd83, 7'd73, 1'b0, 7'd0, 1'b0, 5'd9);
        disp(7'd84, 7'd0, 1'b0, 7'd0, 1'b0, 5'd10);
        for (int c = 0; c < 3; c++) begin
            chk("stall_issued", 32'(issued), 32'd0);
            tick();
        end
        fu_ready = 1'b1;
        #1;
        chk("sel_first_pd", 32'(iss_pd), 32'd81);
        tick();
        chk("sel_second_pd", 32'(iss_pd), 32'd84);
        tick();
        chk("sel_done", 32'(issued), 32'd0);
        chk("sel_occ3", 32'(occupancy), 32'd3);

        // reset with 5 valid entries and a dispatch pending
        fu_ready = 1'b0;
        disp(7'd85, 7'd75, 1'b0, 7'd0, 1'b0, 5'd11);
        disp(7'd86, 7'd76, 1'b0, 7'd0, 1'b0, 5'd12);
        chk("pre_rst_occ5", 32'(occupancy), 32'd5);
        reset = 1'b1; fu_ready = 1'b1;
        set_op(7'd87, 7'd1, 1'b1, 7'd2, 1'b1, 5'd13, 32'h0);
        disp_valid = 1'b1;
        tick();
        reset = 1'b0; disp_valid = 1'b0;
        #1;
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_issued", 32'(issued), 32'd0);
        chk("mid_rst_ready", 32'(disp_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station for the integer ALU pipe.
- Accepts renamed ALU micro-ops from dispatch and holds them until both source operands are ready.
- Listens to two wakeup broadcast buses and issues at most one ready op per cycle to the ALU functional unit.
- The ALU reads PRF data for ps1/ps2 in the issue cycle. On a branch mispredict, all entries younger than the mispredicting ROB tag are squashed.

Parameters:
- DEPTH, 8, number of RS entries (power of 2, 2..16).
- PTAG_W, 7, physical register tag width.
- ROB_SIZE, 16, ROB entries; ROB tags are 5 bits and wrap ROB_SIZE-1 -> 0.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- disp_valid  input  1  dispatch presents an op
- disp_ready  output  1  a free entry exists (high if any entry is invalid)
- disp_pd  input  PTAG_W  destination physical tag
- disp_ps1, disp_ps2  input  PTAG_W  source physical tags
- disp_ps1_rdy, disp_ps2_rdy  input  1  source already ready per busy table
- disp_rob_index  input  5  ROB tag
- disp_opcode  input  7  opcode
- disp_func3  input  3  func3
- disp_func7  input  7  func7
- disp_imm  input  32  immediate
- wk0_valid, wk1_valid  input  1  wakeup broadcast valid
- wk0_tag, wk1_tag  input  PTAG_W  tag becoming ready
- fu_ready  input  1  ALU can accept an op this cycle
- issued  output  1  an op is presented to the ALU this cycle
- iss_pd, iss_ps1, iss_ps2  output  PTAG_W  issued op tags
- iss_rob_index  output  5  issued op ROB tag
- iss_opcode, iss_func3, iss_func7, iss_imm  output  7/3/7/32  issued op fields
- mispredict  input  1  flush younger ops
- mispredict_tag  input  5  ROB tag of the mispredicting branch
- rob_tail  input  5  next ROB tag to be allocated (exclusive end of the younger range)
- occupancy  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Each entry holds: valid, pd, ps1, ps2, rdy1, rdy2, rob_index, opcode, func3, func7, imm.
- Reset (sync): all valid bits are 0, so occupancy=0, disp_ready=1, issued=0. All iss_* outputs are 0.
- Dispatch:
  - disp_ready is combinational (any entry invalid).
  - On disp_valid&&disp_ready&&!mispredict, write the lowest-index invalid entry at the clock edge.
  - Stored rdyN = disp_psN_rdy OR (wk0_valid&&wk0_tag==disp_psN) OR (wk1_valid&&wk1_tag==disp_psN).
  - Physical tag 0 is always treated as ready.
- Wakeup: every cycle, every valid entry sets rdyN when a valid wakeup tag matches psN. Both buses are applied in the same cycle.
- Select (combinational from registered state):
  - Candidate = valid && rdy1 && rdy2.
  - Pick the lowest-index candidate.
  - issued = fu_ready && candidate exists && !mispredict.
  - iss_* = the selected entry's fields when issued, else 0.
- Issue latency: an op is eligible the cycle after dispatch at the earliest. A wakeup in cycle N makes an entry eligible in cycle N+1. There is no same-cycle wakeup-to-issue.
- Dealloc: when issued, the selected entry's valid bit clears at the clock edge.
- Simultaneous dispatch and issue: the issued slot is not reused in the same cycle. The dispatch target is chosen from entries invalid at cycle start, so dispatch with a full RS stalls even if an issue occurs.
- Mispredict (one cycle):
  - Clear every valid entry whose rob_index lies in the circular range (mispredict_tag, rob_tail), i.e. start at (mispredict_tag+1) mod ROB_SIZE and walk to rob_tail, exclusive.
  - If (mispredict_tag+1) mod ROB_SIZE == rob_tail, nothing is flushed.
  - The branch's own entry and older entries survive.
  - During mispredict, dispatch is ignored and issued=0.
- occupancy updates at the edge as +dispatch −issue −flushed.
- Reset mid-operation discards all entries regardless of other inputs.

Test Plan:
- Reset, then dispatch addi with rdy1=1, rdy2=1, pd=5, rob=3, imm=0x10, fu_ready=1 -> issued=1 the next cycle with iss_pd=5, iss_rob_index=3, iss_imm=0x10; occupancy returns 1->0.
- Dispatch sub with ps1=9 not ready; wk0_valid, wk0_tag=9 in cycle N -> issued in cycle N+1, not N. A wakeup on the same cycle as dispatch makes the op eligible the following cycle.
- Fill all 8 entries with not-ready ops -> disp_ready=0 and a 9th disp_valid is not accepted. Wake entry 2 -> it issues, and disp_ready=1 the cycle after.
- Entries with rob 14, 15, 0, 1; mispredict with tag=15, rob_tail=2 -> entries with rob 0 and 1 are cleared; 14 and 15 remain; occupancy=2; issued=0 that cycle.
- Ready ops in entries 1 and 4 with fu_ready=0 for 3 cycles -> issued=0 throughout. When fu_ready rises, entry 1 issues, then entry 4 the next cycle.
- Assert reset while 5 entries are valid and disp_valid=1 -> the next cycle has occupancy=0, issued=0, disp_ready=1.
